// File: rtl/network_sequencer_pkg.sv
// Shared types and constants for the network LSTM sequencer and its output serializer.
package network_sequencer_pkg;

  localparam int QN       = 6;
  localparam int QM       = 11;
  localparam int BITWIDTH = QN + QM + 1;

  typedef enum logic [2:0] {
    NET_RST,
    LOAD,
    FIRE,
    WAIT,
    SETTLE,
    DRAIN
  } seq_state_e;

  // Ceiling log2 with a floor of 1, so single-entry counters still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/network_out_serializer.sv
// Captures a packed vector and streams it out one word per valid/ready beat, word 0 first.
module network_out_serializer
  import network_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          capture,
  input  logic [NUM_WORDS*BITWIDTH-1:0] vec_in,
  input  logic                          drain,
  input  logic                          seq_final,
  input  logic                          out_ready,
  output logic [BITWIDTH-1:0]           out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          out_seq_last,
  output logic                          done
);
  localparam int NW = clog2(NUM_WORDS);

  logic [NUM_WORDS*BITWIDTH-1:0] cap_q, cap_d;
  logic [NW-1:0]                 nrn_q, nrn_d, nrn_nxt;
  logic [BITWIDTH-1:0]           data_q, data_d;
  logic                          last_q, last_d, seq_last_q, seq_last_d;
  logic                          hs;

  assign out_valid    = drain;
  assign hs           = drain && out_ready;
  assign done         = hs && (nrn_q == NW'(NUM_WORDS - 1));
  assign nrn_nxt      = nrn_q + 1'b1;
  assign out_data     = data_q;
  assign out_last     = last_q;
  assign out_seq_last = seq_last_q;

  // out_data is preloaded with the next word so it is a flop output, not a mux.
  always_comb begin
    cap_d      = cap_q;
    nrn_d      = nrn_q;
    data_d     = data_q;
    last_d     = last_q;
    seq_last_d = seq_last_q;
    if (capture) begin
      cap_d      = vec_in;
      nrn_d      = '0;
      data_d     = vec_in[BITWIDTH-1:0];
      last_d     = (NUM_WORDS == 1);
      seq_last_d = (NUM_WORDS == 1) && seq_final;
    end else if (done) begin
      nrn_d      = '0;
      data_d     = '0;
      last_d     = 1'b0;
      seq_last_d = 1'b0;
    end else if (hs) begin
      nrn_d      = nrn_nxt;
      data_d     = cap_q[nrn_nxt*BITWIDTH +: BITWIDTH];
      last_d     = (nrn_nxt == NW'(NUM_WORDS - 1));
      seq_last_d = (nrn_nxt == NW'(NUM_WORDS - 1)) && seq_final;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_q      <= '0;
      nrn_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      seq_last_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      nrn_q      <= nrn_d;
      data_q     <= data_d;
      last_q     <= last_d;
      seq_last_q <= seq_last_d;
    end
  end

endmodule

// File: rtl/network_sequencer.sv
// Drives the network layer: packs input words, fires newSample, waits for dataReady, drains hidden state.
module network_sequencer
  import network_sequencer_pkg::*;
#(
  parameter int INPUT_SZ       = 2,
  parameter int HIDDEN_SZ      = 8,
  parameter int SEQ_LEN        = 8,
  parameter int NET_RST_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT        = 4095
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [BITWIDTH-1:0]           in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BITWIDTH-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_seq_last,
  output logic [BITWIDTH*INPUT_SZ-1:0]  net_inputVec,
  output logic                          net_newSample,
  output logic                          net_reset,
  input  logic                          net_dataReady,
  input  logic [BITWIDTH*HIDDEN_SZ-1:0] net_outputVec,
  output logic                          error
);
  localparam int CNT_MAX = (TIMEOUT > NET_RST_CYCLES)
                         ? ((TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES)
                         : ((NET_RST_CYCLES > SETTLE_CYCLES) ? NET_RST_CYCLES : SETTLE_CYCLES);
  localparam int CNT_W = clog2(CNT_MAX + 1);
  localparam int WRD_W = clog2(INPUT_SZ);
  localparam int SMP_W = clog2(SEQ_LEN);

  seq_state_e                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [WRD_W-1:0]             word_cnt_q, word_cnt_d;
  logic [SMP_W-1:0]             sample_cnt_q, sample_cnt_d;
  logic [BITWIDTH*INPUT_SZ-1:0] in_vec_q, in_vec_d;
  logic                         new_sample_q, new_sample_d;
  logic                         net_reset_q, net_reset_d;
  logic                         error_q, error_d;
  logic                         drdy_q, drdy_d;
  logic                         rise, capture, burst_done, seq_final;

  assign in_ready      = (state_q == LOAD);
  assign rise          = net_dataReady && !drdy_q;
  assign seq_final     = (sample_cnt_q == SMP_W'(SEQ_LEN - 1));
  assign net_inputVec  = in_vec_q;
  assign net_newSample = new_sample_q;
  assign net_reset     = net_reset_q;
  assign error         = error_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_cnt_d   = word_cnt_q;
    sample_cnt_d = sample_cnt_q;
    in_vec_d     = in_vec_q;
    error_d      = error_q;
    drdy_d       = net_dataReady;
    capture      = 1'b0;
    case (state_q)
      NET_RST: begin
        sample_cnt_d = '0;
        word_cnt_d   = '0;
        if (cnt_q == CNT_W'(NET_RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else cnt_d = cnt_q + 1'b1;
      end
      LOAD: if (in_valid) begin
        in_vec_d[word_cnt_q*BITWIDTH +: BITWIDTH] = in_data;
        if (word_cnt_q == WRD_W'(INPUT_SZ - 1)) begin
          word_cnt_d = '0;
          state_d    = FIRE;
        end else word_cnt_d = word_cnt_q + 1'b1;
      end
      FIRE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = NET_RST;
        end else cnt_d = cnt_q + 1'b1;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = DRAIN;
        end else cnt_d = cnt_q + 1'b1;
      end
      DRAIN: if (burst_done) begin
        cnt_d = '0;
        if (seq_final) state_d = NET_RST;
        else begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          state_d      = LOAD;
        end
      end
      default: state_d = NET_RST;
    endcase
    // Strobes follow the next state so they line up with the state they belong to.
    new_sample_d = (state_d == FIRE);
    net_reset_d  = (state_d == NET_RST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= NET_RST;
      cnt_q        <= '0;
      word_cnt_q   <= '0;
      sample_cnt_q <= '0;
      in_vec_q     <= '0;
      new_sample_q <= 1'b0;
      net_reset_q  <= 1'b1;
      error_q      <= 1'b0;
      drdy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_cnt_q   <= word_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      in_vec_q     <= in_vec_d;
      new_sample_q <= new_sample_d;
      net_reset_q  <= net_reset_d;
      error_q      <= error_d;
      drdy_q       <= drdy_d;
    end
  end

  network_out_serializer #(.NUM_WORDS(HIDDEN_SZ)) u_ser (
    .clock        (clock),
    .reset        (reset),
    .capture      (capture),
    .vec_in       (net_outputVec),
    .drain        (state_q == DRAIN),
    .seq_final    (seq_final),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_seq_last (out_seq_last),
    .done         (burst_done)
  );

endmodule

// File: tb/tb_network_sequencer.sv
// Randomized scoreboard bench for network_sequencer with a behavioural network model.
module tb_network_sequencer;
  localparam int BW = 18, IS = 2, HS = 8, SL = 8, TO = 31;

  logic               clock = 1'b0, reset = 1'b0;
  logic [BW-1:0]      in_data, out_data;
  logic               in_valid, in_ready, out_valid, out_ready, out_last, out_seq_last;
  logic [IS*BW-1:0]   net_inputVec;
  logic               net_newSample, net_reset, net_dataReady, error;
  logic [HS*BW-1:0]   net_outputVec;

  network_sequencer #(.INPUT_SZ(IS), .HIDDEN_SZ(HS), .SEQ_LEN(SL), .NET_RST_CYCLES(4),
                      .SETTLE_CYCLES(2), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_seq_last(out_seq_last), .net_inputVec(net_inputVec), .net_newSample(net_newSample),
    .net_reset(net_reset), .net_dataReady(net_dataReady), .net_outputVec(net_outputVec),
    .error(error));

  always #5 clock = ~clock;

  typedef struct { logic [BW-1:0] d; logic last; logic seq_last; } beat_t;
  beat_t out_q[$];

  int n_cmp = 0, n_err = 0, cyc = 0, fire_n = 0, n_beats = 0, edge_cyc = -100;
  logic hang = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Offers one word and holds it until the sequencer takes it; returns just after the accepting edge.
  task automatic send(input logic [BW-1:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clock);
    while (!in_ready && t < 400) begin @(negedge clock); t++; end
    if (!in_ready) bound_fail("in_ready_wait");
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Network model: responds to each strobe after a delay with a fresh hidden-state vector.
  initial begin
    int d;
    beat_t b;
    logic [BW-1:0] v;
    net_dataReady = 1'b0;
    net_outputVec = '0;
    forever begin
      @(negedge clock);
      if (hang) net_dataReady = 1'b1;
      else if (net_newSample) begin
        d = (fire_n == 0) ? 20 : $urandom_range(1, 25);
        repeat (d) @(posedge clock);
        #1;
        for (int k = 0; k < HS; k++) begin
          v = (fire_n == 0) ? BW'(k + 1) : BW'($urandom);
          net_outputVec[k*BW +: BW] = v;
          b.d        = v;
          b.last     = (k == HS - 1);
          b.seq_last = (k == HS - 1) && (fire_n % SL == SL - 1);
          out_q.push_back(b);
        end
        net_dataReady = 1'b1;
        edge_cyc = cyc;
        fire_n++;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1 net_dataReady = 1'b0;
      end
    end
  end

  // Downstream: random back-pressure plus one long stall inside the first burst.
  initial begin
    logic did_stall;
    did_stall = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (n_beats == 3 && !did_stall) begin
        did_stall = 1'b1;
        out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b1;
      end else out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: scoreboard pop, stall stability, first-beat latency.
  initial begin
    beat_t e;
    logic stalled, prev_ov, held_last;
    logic [BW-1:0] held_d;
    stalled = 1'b0; prev_ov = 1'b0; held_last = 1'b0; held_d = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (out_valid && !prev_ov) chk("first_valid_latency", 64'(cyc - edge_cyc), 64'd3);
        if (stalled && out_valid) begin
          chk("stall_data", out_data, held_d);
          chk("stall_last", out_last, held_last);
        end
        if (out_valid && out_ready) begin
          n_beats++;
          if (out_q.size() == 0) bound_fail("unexpected_beat");
          else begin
            e = out_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.last);
            chk("out_seq_last", out_seq_last, e.seq_last);
          end
        end
      end
      stalled   = reset && out_valid && !out_ready;
      held_d    = out_data;
      held_last = out_last;
      prev_ov   = reset && out_valid;
    end
  end

  // Input monitor: packs accepted words and checks the strobe and vector one cycle later.
  initial begin
    int wcnt, exp_strobe, rst_run;
    logic [IS*BW-1:0] acc, exp_vec;
    wcnt = 0; exp_strobe = -1; rst_run = 0; acc = '0; exp_vec = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        wcnt = 0; rst_run = 0;
      end else begin
        if (net_newSample || cyc == exp_strobe) begin
          chk("strobe_cycle", 64'(cyc), 64'(exp_strobe));
          chk("strobe_high", net_newSample, 1'b1);
          chk("net_inputVec", net_inputVec, exp_vec);
        end
        if (in_valid && in_ready) begin
          acc[wcnt*BW +: BW] = in_data;
          wcnt++;
          if (wcnt == IS) begin
            wcnt = 0; exp_vec = acc; exp_strobe = cyc + 1;
          end
        end
        if (net_reset) begin
          rst_run++;
          chk("nrst_in_ready", in_ready, 1'b0);
          chk("nrst_quiet", {out_valid, out_last, out_seq_last, net_newSample, out_data}, '0);
        end else if (rst_run > 0) begin
          chk("net_reset_len", 64'(rst_run), 64'd4);
          chk("load_after_nrst", in_ready, 1'b1);
          rst_run = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    bound_fail("watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    int t, f;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clock);
    chk("rst_net_reset", net_reset, 1'b1);
    chk("rst_newSample", net_newSample, 1'b0);
    chk("rst_inputVec", net_inputVec, '0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", {out_last, out_seq_last}, 2'b00);
    chk("rst_out_data", out_data, '0);
    chk("rst_error", error, 1'b0);
    @(posedge clock); #1 reset = 1'b1;

    send(18'h00800);
    send(18'h3F800);
    for (int s = 1; s < 2 * SL; s++)
      for (int i = 0; i < IS; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        send(BW'($urandom));
      end

    t = 0;
    while ((fire_n < 2 * SL || out_q.size() != 0) && t < 4000) begin @(negedge clock); t++; end
    chk("all_beats_drained", 64'(out_q.size()), 64'd0);
    chk("beat_count", 64'(n_beats), 64'(2 * SL * HS));
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clock); t++; end
    chk("idle_in_load", in_ready, 1'b1);
    chk("error_clear", error, 1'b0);

    // dataReady pinned high across FIRE: no edge, so the wait must time out.
    @(posedge clock); #1 hang = 1'b1;
    @(posedge clock); #1;
    send(BW'($urandom));
    send(BW'($urandom));
    t = 0;
    do begin @(negedge clock); t++; end while (!net_newSample && t < 20);
    f = cyc;
    t = 0;
    do begin @(negedge clock); t++; end while (!error && t < 100);
    chk("timeout_latency", 64'(cyc - f), 64'(TO + 1));
    repeat (30) @(negedge clock);
    chk("error_sticky", error, 1'b1);
    chk("load_after_timeout", in_ready, 1'b1);
    chk("no_capture_on_timeout", 64'(n_beats), 64'(2 * SL * HS));

    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("rst2_error", error, 1'b0);
    chk("rst2_net_reset", net_reset, 1'b1);
    chk("rst2_in_ready", in_ready, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
